// File: rtl/uart_pkg.sv
// Shared UART types and constants: receive-FSM state encoding, data width and idle line level.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // PARITY exists in every build so the encoding is stable; only the parity build reaches it.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is a parameter.
module uart_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: synchronizes rxLine, frames LSB-first characters and emits one-cycle write/error strobes.
// Optional 8E1 framing is enabled by defining UART_RX_PARITY_EN (default build is 8N1).
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int ClocksPerBit = 434
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rxLine,
  output logic                      dataWriteEnable,
  output logic [UART_DATA_BITS-1:0] dataWrite,
  output logic                      frameError,
  output logic                      busy
);

  localparam int CountBits = $clog2(ClocksPerBit);
  localparam logic [CountBits-1:0] FullCount = CountBits'(ClocksPerBit - 1);
  localparam logic [CountBits-1:0] HalfCount = CountBits'(ClocksPerBit / 2 - 1);
  localparam logic [2:0]            LastBit   = 3'(UART_DATA_BITS - 1);

  logic rx_sync;

  uart_sync2 #(
    .ResetVal(UART_IDLE_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rxLine),
    .q_o  (rx_sync)
  );

  rx_state_t                 state_q;
  logic [CountBits-1:0]      counter_q;
  logic [CountBits-1:0]      counter_d;
  logic [2:0]                bit_index_q;
  logic                      armed_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] shift_d;
  logic                      write_en_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      frame_err_q;
  logic                      stop_good;
`ifdef UART_RX_PARITY_EN
  logic                      parity_err_q;
`endif

  assign counter_d = counter_q + CountBits'(1);
  assign shift_d   = {rx_sync, shift_q[UART_DATA_BITS-1:1]};

`ifdef UART_RX_PARITY_EN
  assign stop_good = rx_sync && !parity_err_q;
`else
  assign stop_good = rx_sync;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      bit_index_q  <= '0;
      armed_q      <= 1'b0;
      shift_q      <= '0;
      write_en_q   <= 1'b0;
      data_q       <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      write_en_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
`ifdef UART_RX_PARITY_EN
          parity_err_q <= 1'b0;
`endif
          // armed requires a high level first, so a line stuck low never starts a frame
          if (armed_q && !rx_sync) begin
            state_q   <= START;
            counter_q <= '0;
            armed_q   <= 1'b0;
          end else if (rx_sync) begin
            armed_q <= 1'b1;
          end
        end
        START: begin
          if (counter_q == HalfCount) begin
            counter_q   <= '0;
            bit_index_q <= '0;
            state_q     <= rx_sync ? IDLE : DATA;
          end else begin
            counter_q <= counter_d;
          end
        end
        DATA: begin
          if (counter_q == FullCount) begin
            counter_q   <= '0;
            shift_q     <= shift_d;
            bit_index_q <= bit_index_q + 3'd1;
            if (bit_index_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            counter_q <= counter_d;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (counter_q == FullCount) begin
            counter_q    <= '0;
            parity_err_q <= (^shift_q) != rx_sync;
            state_q      <= STOP;
          end else begin
            counter_q <= counter_d;
          end
        end
`endif
        STOP: begin
          if (counter_q == FullCount) begin
            counter_q <= '0;
            armed_q   <= 1'b0;
            state_q   <= IDLE;
            if (stop_good) begin
              write_en_q <= 1'b1;
              data_q     <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            counter_q <= counter_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          counter_q <= '0;
          armed_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dataWriteEnable = write_en_q;
  assign dataWrite       = data_q;
  assign frameError      = frame_err_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer with ClocksPerBit=16: table of frames plus hand-written glitch/reset sequences.
module tb_uart_rx_framer;

  localparam int CPB = 16;
  localparam int W   = 9;   // {is_error, byte}

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_line;
  logic       data_write_enable;
  logic [7:0] data_write;
  logic       frame_error;
  logic       busy;

  int tests_run = 0;
  int fail_cnt  = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   last_good = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       flip_parity;
    int         idle_bits;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];

  uart_rx_framer #(.ClocksPerBit(CPB)) dut (
    .clk            (clk),
    .reset          (reset),
    .rxLine         (rx_line),
    .dataWriteEnable(data_write_enable),
    .dataWrite      (data_write),
    .frameError     (frame_error),
    .busy           (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every strobe must match the oldest expected entry
  always @(negedge clk) begin
    if (data_write_enable && frame_error) begin
      tests_run++;
      fail_cnt++;
      $display("FAIL strobe_overlap: got both strobes high, expected at most one");
    end else if (data_write_enable || frame_error) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        fail_cnt++;
        $display("FAIL unexpected_strobe: got err=%0b data=%0h, expected no strobe",
                 frame_error, data_write);
      end else begin
        check("strobe_result", {23'd0, frame_error, data_write}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx_line = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic flip_parity, input logic exp_err);
    if (exp_err) exp_q.push_back({1'b1, last_good});
    else begin
      exp_q.push_back({1'b0, d});
      last_good = d;
    end
    drive_bit(1'b0);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ flip_parity);
`else
    if (flip_parity) begin end
`endif
    drive_bit(stop_bit);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 0, 1'b0};   // back-to-back with next
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 2, 1'b1};   // bad stop bit
    vecs[4] = '{8'h07, 1'b1, 1'b0, 1, 1'b0};
`ifdef UART_RX_PARITY_EN
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1, 1'b1};   // parity bit 0 for 8'h07
`else
    vecs[5] = '{8'h07, 1'b1, 1'b1, 1, 1'b0};
`endif
    vecs[6] = '{8'hC3, 1'b1, 1'b0, 1, 1'b0};

    // reset block
    reset   = 1'b1;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_we",   {31'd0, data_write_enable}, 32'd0);
    check("reset_data", {24'd0, data_write},        32'd0);
    check("reset_ferr", {31'd0, frame_error},       32'd0);
    check("reset_busy", {31'd0, busy},              32'd0);
    reset = 1'b0;
    idle_bits(1);

    // table-driven frames
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].flip_parity, vecs[v].exp_err);
      if (vecs[v].idle_bits > 0) begin
        idle_bits(vecs[v].idle_bits);
        check("drained", exp_q.size(), 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("data_hold", {24'd0, data_write}, {24'd0, last_good});
      end
    end

    // short low glitch on idle line must be rejected silently
    @(negedge clk);
    rx_line = 1'b0;
    repeat (5) @(negedge clk);
    rx_line = 1'b1;
    idle_bits(2);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_quiet", exp_q.size(), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    check("after_glitch", exp_q.size(), 32'd0);
    check("after_glitch_data", {24'd0, data_write}, 32'h81);

    // reset in the middle of data bit 4 abandons the frame
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1 ^ i[0]);
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    rx_line = 1'b1;
    last_good = 8'h00;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_data", {24'd0, data_write}, 32'd0);
    idle_bits(2);
    check("midreset_quiet", exp_q.size(), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    check("after_reset", exp_q.size(), 32'd0);
    check("after_reset_data", {24'd0, data_write}, 32'h5A);

    // line held low (break) gives exactly one error, then nothing until it returns high
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    repeat (3) drive_bit(1'b0);
    idle_bits(2);
    check("break_single", exp_q.size(), 32'd0);
    check("break_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
